// File: rtl/simd_pkg.sv
// Shared types, widths and default latencies for the SIMD issue/pipeline controller.
package simd_pkg;

  localparam int OP_SEL_WIDTH    = 4;
  // Address width carried by the decoder; a controller's ADDR_WIDTH must not exceed it.
  localparam int CTRL_ADDR_WIDTH = 10;
  localparam int DEF_BRAM_LAT    = 1;
  localparam int DEF_EXEC_LAT    = 2;

  typedef struct packed {
    logic [CTRL_ADDR_WIDTH-1:0] a_addr;
    logic [CTRL_ADDR_WIDTH-1:0] b_addr;
    logic [CTRL_ADDR_WIDTH-1:0] r_addr;
    logic [OP_SEL_WIDTH-1:0]    pe_op;
    logic [1:0]                 dot_ctrl;
    logic                       wen;
    logic                       r_sel;
  } ctrl_t;

  function automatic int pipe_depth(input int bram_lat, input int exec_lat);
    return 1 + bram_lat + exec_lat;
  endfunction

endpackage

// File: rtl/simd_hazard_unit.sv
// RAW hazard detect: flags an incoming read of any address a valid, writing slot will store.
module simd_hazard_unit
  import simd_pkg::*;
#(
  parameter int D          = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic [D-1:0]                 slot_v_i,
  input  logic [D-1:0]                 slot_wen_i,
  input  logic [D-1:0][ADDR_WIDTH-1:0] slot_raddr_i,
  input  logic [ADDR_WIDTH-1:0]        a_addr_i,
  input  logic [ADDR_WIDTH-1:0]        b_addr_i,
  output logic                         hazard_o
);

  always_comb begin
    hazard_o = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (slot_v_i[k] && slot_wen_i[k] &&
          ((slot_raddr_i[k] == a_addr_i) || (slot_raddr_i[k] == b_addr_i)))
        hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/simd_pipe_ctrl.sv
// Full-rate LOAD/EXEC/STORE sequencer for the SIMD datapath with RAW stalling.
// Optional perf counters (perf_issued_o/perf_stall_o/perf_writes_o) under SIMD_PERF_CNT_EN.
module simd_pipe_ctrl
  import simd_pkg::*;
#(
  parameter int PE_COUNT   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 1024,
  parameter int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  parameter int BRAM_LAT   = DEF_BRAM_LAT,
  parameter int EXEC_LAT   = DEF_EXEC_LAT
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  ctrl_t                          in_ctrl_i,
  output logic [ADDR_WIDTH-1:0]          bram_a_addr_o,
  output logic [ADDR_WIDTH-1:0]          bram_b_addr_o,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_a_dout_i,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_b_dout_i,
  output logic                           exec_valid_o,
  output logic [OP_SEL_WIDTH-1:0]        exec_pe_op_o,
  output logic [1:0]                     exec_dot_ctrl_o,
  output logic [PE_COUNT*DATA_WIDTH-1:0] exec_a_o,
  output logic [PE_COUNT*DATA_WIDTH-1:0] exec_b_o,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] elem_out_i,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] dot_out_i,
  output logic [ADDR_WIDTH-1:0]          bram_r_addr_o,
  output logic                           bram_r_wen_o,
  output logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_din_o,
  output logic                           busy_o
`ifdef SIMD_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_issued_o,
  output logic [31:0]                    perf_stall_o,
  output logic [31:0]                    perf_writes_o
`endif
);

  localparam int D  = pipe_depth(BRAM_LAT, EXEC_LAT);
  localparam int EX = BRAM_LAT;
  localparam int WR = D - 1;

  // Slot k holds the op k+1 cycles after its accept edge; a/b addresses are not carried.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [OP_SEL_WIDTH-1:0] pe_op;
    logic [1:0]              dot_ctrl;
    logic                    wen;
    logic                    r_sel;
  } slot_t;

  logic [D-1:0]                 slot_v_q, slot_v_d;
  slot_t                        slot_q [D];
  slot_t                        slot_d [D];
  logic [ADDR_WIDTH-1:0]        a_addr_q, a_addr_d;
  logic [ADDR_WIDTH-1:0]        b_addr_q, b_addr_d;
  logic [D-1:0]                 slot_wen;
  logic [D-1:0][ADDR_WIDTH-1:0] slot_raddr;
  logic [ADDR_WIDTH-1:0]        in_a_addr, in_b_addr;
  logic                         hazard;
  logic                         accept;

  assign in_a_addr  = in_ctrl_i.a_addr[ADDR_WIDTH-1:0];
  assign in_b_addr  = in_ctrl_i.b_addr[ADDR_WIDTH-1:0];
  assign in_ready_o = ~hazard;
  assign accept     = in_valid_i & ~hazard;

  always_comb begin
    for (int k = 0; k < D; k++) begin
      slot_wen[k]   = slot_q[k].wen;
      slot_raddr[k] = slot_q[k].r_addr;
    end
  end

  simd_hazard_unit #(
    .D          (D),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hazard (
    .slot_v_i     (slot_v_q),
    .slot_wen_i   (slot_wen),
    .slot_raddr_i (slot_raddr),
    .a_addr_i     (in_a_addr),
    .b_addr_i     (in_b_addr),
    .hazard_o     (hazard)
  );

  always_comb begin
    slot_v_d           = {slot_v_q[D-2:0], accept};
    slot_d[0].r_addr   = in_ctrl_i.r_addr[ADDR_WIDTH-1:0];
    slot_d[0].pe_op    = in_ctrl_i.pe_op;
    slot_d[0].dot_ctrl = in_ctrl_i.dot_ctrl;
    slot_d[0].wen      = in_ctrl_i.wen;
    slot_d[0].r_sel    = in_ctrl_i.r_sel;
    for (int k = 1; k < D; k++) slot_d[k] = slot_q[k-1];
    a_addr_d = accept ? in_a_addr : a_addr_q;
    b_addr_d = accept ? in_b_addr : b_addr_q;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < D; k++) slot_q[k] <= slot_d[k];
    if (!rstn) begin
      slot_v_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
    end else begin
      slot_v_q <= slot_v_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
    end
  end

  assign bram_a_addr_o   = a_addr_q;
  assign bram_b_addr_o   = b_addr_q;
  assign exec_valid_o    = slot_v_q[EX];
  assign exec_pe_op_o    = slot_q[EX].pe_op;
  assign exec_dot_ctrl_o = slot_q[EX].dot_ctrl;
  assign exec_a_o        = bram_a_dout_i;
  assign exec_b_o        = bram_b_dout_i;
  assign bram_r_wen_o    = slot_v_q[WR] & slot_q[WR].wen;
  assign bram_r_addr_o   = slot_q[WR].r_addr;
  assign bram_r_din_o    = slot_q[WR].r_sel ? dot_out_i : elem_out_i;
  assign busy_o          = |slot_v_q;

`ifdef SIMD_PERF_CNT_EN
  logic [31:0] issued_q, stall_q, writes_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      issued_q <= '0;
      stall_q  <= '0;
      writes_q <= '0;
    end else begin
      if (accept)                issued_q <= issued_q + 32'd1;
      if (in_valid_i && hazard)  stall_q  <= stall_q + 32'd1;
      if (bram_r_wen_o)          writes_q <= writes_q + 32'd1;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
  assign perf_writes_o = writes_q;
`endif

endmodule
